// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl
//   Sequencer and configuration controller for a right-shifting Fibonacci
//   LFSR. A start command captures seed, tap mask and run length. The block
//   then steps the LFSR exactly `len` times, one step per accepted stream
//   beat, and pulses `done` when the run is complete.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   start      command pulse, sampled only in IDLE
//   abort      run termination, sampled only in RUN
//   seed/taps  initial register value / feedback mask, captured on start
//   len        number of bits to emit, captured on start
//   bit_out    stream bit (lfsr_q[0]); bit_valid/bit_ready handshake
//   busy       high in RUN and DONE
//   done       one-cycle completion pulse
//   err_cfg    one-cycle pulse, start rejected (seed or taps zero)
//   lfsr_q     current LFSR register
//   remaining  bits still to emit
module lfsr_seq_ctrl #(
  parameter int REG_SIZE = 8,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [REG_SIZE-1:0] seed,
  input  logic [REG_SIZE-1:0] taps,
  input  logic [CNT_W-1:0]    len,
  output logic                bit_out,
  output logic                bit_valid,
  input  logic                bit_ready,
  output logic                busy,
  output logic                done,
  output logic                err_cfg,
  output logic [REG_SIZE-1:0] lfsr_q,
  output logic [CNT_W-1:0]    remaining
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [REG_SIZE-1:0] taps_q;
  logic                fb;
  logic                hs;

  assign fb      = ^(lfsr_q & taps_q);
  assign hs      = bit_valid & bit_ready;
  // bit_out is a direct tap of the register, so it is stable exactly as
  // long as lfsr_q is, i.e. until the next handshake.
  assign bit_out = lfsr_q[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lfsr_q    <= '0;
      taps_q    <= '0;
      remaining <= '0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_cfg   <= 1'b0;
    end else begin
      done    <= 1'b0;
      err_cfg <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (seed == '0 || taps == '0) begin
              // All-zero seed locks the LFSR, zero taps give a constant
              // stream: reject without touching the register.
              err_cfg <= 1'b1;
            end else begin
              lfsr_q    <= seed;
              taps_q    <= taps;
              remaining <= len;
              busy      <= 1'b1;
              if (len == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state     <= RUN;
                bit_valid <= 1'b1;
              end
            end
          end
        end
        RUN: begin
          if (hs) begin
            lfsr_q    <= {fb, lfsr_q[REG_SIZE-1:1]};
            remaining <= remaining - CNT_W'(1);
          end
          // Abort wins over completion; a coincident beat still counts.
          if (abort) begin
            state     <= IDLE;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (hs && remaining == CNT_W'(1)) begin
            state     <= DONE;
            bit_valid <= 1'b0;
            done      <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          bit_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl (REG_SIZE=8, CNT_W=16).
module tb_lfsr_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  seed;
  logic [7:0]  taps;
  logic [15:0] len;
  logic        bit_out;
  logic        bit_valid;
  logic        bit_ready;
  logic        busy;
  logic        done;
  logic        err_cfg;
  logic [7:0]  lfsr_q;
  logic [15:0] remaining;

  int n_checks = 0;
  int n_fail   = 0;

  lfsr_seq_ctrl #(.REG_SIZE(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .seed(seed), .taps(taps), .len(len),
    .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .busy(busy), .done(done), .err_cfg(err_cfg),
    .lfsr_q(lfsr_q), .remaining(remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // seed 0x01, taps 0x71, len 4: bits 1,0,0,0 with register 01,80,40,A0,
  // ending at D0. `stall` cycles of bit_ready=0 precede the first beat.
  task automatic run_basic(input int stall);
    logic [7:0] exp_lfsr [4];
    logic       exp_bit  [4];
    exp_lfsr = '{8'h01, 8'h80, 8'h40, 8'hA0};
    exp_bit  = '{1'b1, 1'b0, 1'b0, 1'b0};
    seed = 8'h01; taps = 8'h71; len = 16'd4;
    bit_ready = (stall == 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", bit_valid, 1);
      check("stall_bit", bit_out, 1);
      check("stall_lfsr", lfsr_q, 8'h01);
      check("stall_rem", remaining, 4);
      tick();
    end
    bit_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("beat_valid", bit_valid, 1);
      check("beat_busy", busy, 1);
      check("beat_bit", bit_out, exp_bit[i]);
      check("beat_lfsr", lfsr_q, exp_lfsr[i]);
      check("beat_rem", remaining, 4 - i);
      check("beat_nodone", done, 0);
      tick();
    end
    check("end_done", done, 1);
    check("end_valid", bit_valid, 0);
    check("end_busy", busy, 1);
    check("end_lfsr", lfsr_q, 8'hD0);
    check("end_rem", remaining, 0);
    tick();
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_lfsr", lfsr_q, 8'hD0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    seed = '0; taps = '0; len = '0; bit_ready = 1'b1;
    tick(); tick();
    check("rst_valid", bit_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_cfg, 0);
    check("rst_lfsr", lfsr_q, 0);
    check("rst_rem", remaining, 0);
    reset = 1'b1;
    tick();

    // basic run, then with backpressure
    run_basic(0);
    run_basic(3);

    // config errors: zero seed, then zero taps
    seed = 8'h00; taps = 8'h71; len = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    check("errs_pulse", err_cfg, 1);
    check("errs_busy", busy, 0);
    check("errs_valid", bit_valid, 0);
    check("errs_lfsr", lfsr_q, 8'hD0);
    tick();
    check("errs_clear", err_cfg, 0);
    seed = 8'h01; taps = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    check("errt_pulse", err_cfg, 1);
    check("errt_busy", busy, 0);
    check("errt_lfsr", lfsr_q, 8'hD0);
    tick();
    check("errt_clear", err_cfg, 0);

    // len == 0
    seed = 8'h55; taps = 8'h71; len = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("len0_done", done, 1);
    check("len0_busy", busy, 1);
    check("len0_valid", bit_valid, 0);
    check("len0_lfsr", lfsr_q, 8'h55);
    tick();
    check("len0_done_clr", done, 0);
    check("len0_busy_clr", busy, 0);
    check("len0_valid2", bit_valid, 0);

    // abort after 3 beats; a start during RUN is ignored
    seed = 8'h01; taps = 8'h71; len = 16'd10; bit_ready = 1'b0; start = 1'b1;
    tick();
    seed = 8'h33; len = 16'd2;  // start still high, now in RUN
    tick();
    start = 1'b0;
    check("runstart_lfsr", lfsr_q, 8'h01);
    check("runstart_rem", remaining, 10);
    check("runstart_valid", bit_valid, 1);
    bit_ready = 1'b1;
    tick(); tick(); tick();
    check("abort_pre_lfsr", lfsr_q, 8'hA0);
    check("abort_pre_rem", remaining, 7);
    bit_ready = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", bit_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_rem", remaining, 7);
    check("abort_lfsr", lfsr_q, 8'hA0);
    tick();
    check("abort_nodone", done, 0);

    // abort coincident with a handshake: beat still applies
    seed = 8'h01; taps = 8'h71; len = 16'd4; bit_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abhs_valid", bit_valid, 0);
    check("abhs_lfsr", lfsr_q, 8'h80);
    check("abhs_rem", remaining, 3);
    check("abhs_done", done, 0);

    // asynchronous reset mid-run
    seed = 8'h01; taps = 8'h71; len = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #3 reset = 1'b0;
    #1;
    check("arst_valid", bit_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_lfsr", lfsr_q, 0);
    check("arst_rem", remaining, 0);
    tick();
    reset = 1'b1;
    tick();
    check("arst_idle_busy", busy, 0);
    check("arst_idle_valid", bit_valid, 0);
    run_basic(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_ctrl.md
# lfsr_seq_ctrl

Sequencer and configuration controller for the team's LFSR datapath. It captures a seed, tap mask and run length on a start command and steps a right-shifting Fibonacci LFSR exactly `len` times. Each generated bit goes out over a valid/ready bit stream with full backpressure, and the block signals completion. It sits between the host/config logic and any downstream bit consumer (scrambler, test-pattern sink).

## Interface
- `REG_SIZE`, 8, LFSR register width (≥2)
- `CNT_W`, 16, width of the run-length counter
- `clk`  input  1  system clock; all state updates on rising edge
- `reset`  input  1  asynchronous, active-low reset (asserted when 0)
- `start`  input  1  command pulse; sampled only in IDLE
- `abort`  input  1  terminate a run; sampled only in RUN
- `seed`  input  REG_SIZE  initial register value, captured on accepted start
- `taps`  input  REG_SIZE  feedback mask, captured on accepted start
- `len`  input  CNT_W  number of bits to emit, captured on accepted start
- `bit_out`  output  1  current stream bit = `lfsr_q[0]`
- `bit_valid`  output  1  stream bit valid
- `bit_ready`  input  1  consumer accepts bit
- `busy`  output  1  high in RUN and DONE
- `done`  output  1  one-cycle completion pulse
- `err_cfg`  output  1  one-cycle pulse: start rejected (seed==0 or taps==0)
- `lfsr_q`  output  REG_SIZE  current LFSR register
- `remaining`  output  CNT_W  bits still to emit

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - seed==0 or taps==0: err_cfg=1 next cycle, stay IDLE, no register change.
  - len==0: load seed/taps, go to DONE with no beats emitted.
  - Otherwise: lfsr_q←seed, taps_q←taps, remaining←len, go to RUN.
- RUN: bit_valid=1, bit_out=lfsr_q[0].
  - Handshake (bit_valid & bit_ready): lfsr_q←{fb, lfsr_q[REG_SIZE-1:1]}, remaining←remaining−1. fb = XOR-reduce(lfsr_q & taps_q).
  - Handshake with remaining==1: go to DONE.
  - No handshake: lfsr_q, remaining and bit_out hold.
- abort in RUN: go to IDLE next cycle, regardless of handshake in the same cycle. A coincident handshake still completes (shift and decrement apply). No done pulse.
- DONE: done=1 for one cycle, then IDLE.
- lfsr_q retains its final value in IDLE. The last value is readable after done.
- start outside IDLE and abort outside RUN are ignored.
- Reset (any time, including mid-run): state IDLE; lfsr_q, taps_q and remaining =0; bit_valid, busy, done, err_cfg =0. A partial run is lost.

## Timing
- start accepted at edge k → bit_valid=1 and busy=1 from cycle k+1.
- First bit_out = seed[0].
- Valid rule: once bit_valid=1, it and bit_out stay stable until the handshake, or until abort/reset.
- Throughput: one bit per cycle while bit_ready=1.
- Last handshake at edge m → bit_valid=0 and done=1 in cycle m+1 → IDLE (busy=0) in cycle m+2.
- A new start is accepted in the first IDLE cycle.
- len==0 start at edge k → done=1 in cycle k+1, bit_valid never asserts.
- err_cfg: start at edge k → err_cfg=1 in cycle k+1 only; busy stays 0.
- remaining wraps never: counts from len down to 0, then the FSM leaves RUN.

## Test plan
- Basic run: REG_SIZE=8, seed=0x01, taps=0x71, len=4, bit_ready=1 → bits 1,0,0,0 on 4 consecutive cycles. Final lfsr_q=0xD0, done pulse one cycle after the 4th beat, remaining=0.
- Backpressure: same config, bit_ready=0 for 3 cycles after first valid → bit_out=1, lfsr_q=0x01 and remaining=4 held stable. Then the same 4 bits and 0xD0 are produced.
- Config errors: start with seed=0x00 → err_cfg single pulse, busy=0, lfsr_q unchanged. Repeat with taps=0x00 → same result.
- len=0: start with valid seed/taps, len=0 → done pulse at k+1, zero beats, busy high only in the DONE cycle.
- Abort: len=10, abort after 3 beats → bit_valid low next cycle, remaining=7, no done. start during RUN is ignored. A new start afterward works.
- Reset mid-run: assert reset low during RUN asynchronously (between edges) → all outputs 0 immediately. After release, FSM in IDLE and a fresh run behaves as in the basic-run case.
